dpc_bp_lut_scheduler: RTL

//  Owns the manual bad-pixel table RAM and schedules its single port between the AXI config path and the detector.
//  - Config path: wen_lut/waddr_lut/wdata_lut writes and cfg read requests.
//  - Detector path: at each start-of-frame, streams entries 0..manual_bp_num-1 in order over a valid/ready port.

---
 rtl/dpc_bp_pkg.sv | 16 +
 rtl/dpc_bp_sp_ram.sv | 30 +++
 rtl/dpc_bp_lut_scheduler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dpc_bp_pkg.sv
// Shared types for the manual bad-pixel table scheduler: FSM states, table entry
// layout, port-grant encoding and the config word offset of entry 0.
package dpc_bp_pkg;

    localparam int unsigned CFG_BASE = 4;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} fsm_t;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } bp_entry_t;

    typedef enum logic [1:0] {GNT_WR, GNT_RD, GNT_FETCH, GNT_NONE} gnt_t;

endpackage

// File: rtl/dpc_bp_sp_ram.sv
// Single-port table RAM with a registered read; one access (read or write) per cycle.
module dpc_bp_sp_ram #(
    parameter int unsigned Depth     = 128,
    parameter int unsigned Width     = 32,
    parameter int unsigned AddrWidth = 7
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [Width-1:0]     i_wdata,
    output logic [Width-1:0]     o_rdata
);

    logic [Width-1:0] r_mem [Depth];
    logic [Width-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dpc_bp_lut_scheduler.sv
// Arbitrates the bad-pixel table RAM between config writes/reads and a per-frame entry stream.
// Optional DPC_BP_SORT_CHECK_EN adds a sticky sort_err flag for out-of-order entries.
module dpc_bp_lut_scheduler
    import dpc_bp_pkg::*;
#(
    parameter int unsigned LUT_INDEX_WIDTH    = 8,
    parameter int unsigned LUT_INDEX_NUM      = 128,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          go,
    input  logic [LUT_INDEX_WIDTH-1:0]    manual_bp_num,
    input  logic                          sof,
    input  logic                          wen_lut,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr_lut,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_lut,
    input  logic                          cfg_rd_req,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] cfg_rd_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_rd_data,
    output logic                          cfg_rd_valid,
    output logic                          bp_valid,
    input  logic                          bp_ready,
    output logic [15:0]                   bp_x,
    output logic [15:0]                   bp_y,
    output logic                          bp_last,
`ifdef DPC_BP_SORT_CHECK_EN
    output logic                          sort_err,
`endif
    output logic                          frame_done
);

    localparam int unsigned RamAw = (LUT_INDEX_NUM > 1) ? $clog2(LUT_INDEX_NUM) : 1;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] AddrNum  = C_S_AXI_ADDR_WIDTH'(LUT_INDEX_NUM);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] AddrBase = C_S_AXI_ADDR_WIDTH'(CFG_BASE);
    localparam logic [LUT_INDEX_WIDTH-1:0]    NumMax   = LUT_INDEX_WIDTH'(LUT_INDEX_NUM);

    fsm_t                          r_state;
    logic [LUT_INDEX_WIDTH-1:0]    r_ptr;
    logic [LUT_INDEX_WIDTH-1:0]    r_n;
    logic                          r_frame_done;
    logic                          r_fetch_vld;
    logic                          r_fetch_last;
    bp_entry_t                     r_fifo_data [2];
    logic [1:0]                    r_fifo_last;
    logic                          r_wp;
    logic                          r_rp;
    logic [1:0]                    r_cnt;
    logic                          r_rd_pend;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_rd_addr;
    logic                          r_rd_vld;
    logic                          r_rd_oor;

    logic [C_S_AXI_ADDR_WIDTH-1:0] w_wr_idx;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_rd_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_rd_idx;
    logic                          w_wr_ok;
    logic                          w_rd_ok;
    logic                          w_rd_req;
    logic                          w_flush;
    logic                          w_pop;
    logic [1:0]                    w_occ;
    logic                          w_fetch_ok;
    gnt_t                          w_gnt;
    logic                          w_ram_en;
    logic                          w_ram_we;
    logic [RamAw-1:0]              w_ram_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_ram_rdata;
    logic [LUT_INDEX_WIDTH-1:0]    w_n_sof;
    bp_entry_t                     w_head;

    // Indices below CFG_BASE wrap to huge values and fall out of range with the rest.
    assign w_wr_idx  = waddr_lut - AddrBase;
    assign w_wr_ok   = wen_lut && (w_wr_idx < AddrNum);
    assign w_rd_req  = cfg_rd_req || r_rd_pend;
    assign w_rd_addr = cfg_rd_req ? cfg_rd_addr : r_rd_addr;
    assign w_rd_idx  = w_rd_addr - AddrBase;
    assign w_rd_ok   = w_rd_idx < AddrNum;
    assign w_n_sof   = (manual_bp_num > NumMax) ? NumMax : manual_bp_num;

    assign w_flush   = !go || sof;
    assign w_head    = r_fifo_data[r_rp];
    assign bp_valid  = (r_cnt != 2'd0);
    assign bp_x      = w_head.x;
    assign bp_y      = w_head.y;
    assign bp_last   = r_fifo_last[r_rp];
    assign w_pop     = bp_valid && bp_ready;

    // Counting this cycle's pop lets a fetch issue every cycle while the consumer keeps up.
    assign w_occ      = r_cnt + {1'b0, r_fetch_vld};
    assign w_fetch_ok = (r_state == STREAM) && !w_flush && (r_ptr != r_n) &&
                        ((w_occ - {1'b0, w_pop}) < 2'd2);

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_wr_ok) begin
            w_gnt = GNT_WR;
        end else if (w_rd_req) begin
            w_gnt = GNT_RD;
        end else if (w_fetch_ok) begin
            w_gnt = GNT_FETCH;
        end
    end

    always_comb begin
        w_ram_en   = 1'b1;
        w_ram_we   = 1'b0;
        w_ram_addr = '0;
        unique case (w_gnt)
            GNT_WR: begin
                w_ram_we   = 1'b1;
                w_ram_addr = w_wr_idx[RamAw-1:0];
            end
            GNT_RD:    w_ram_addr = w_rd_idx[RamAw-1:0];
            GNT_FETCH: w_ram_addr = r_ptr[RamAw-1:0];
            default:   w_ram_en   = 1'b0;
        endcase
    end

    dpc_bp_sp_ram #(
        .Depth     (LUT_INDEX_NUM),
        .Width     (C_S_AXI_DATA_WIDTH),
        .AddrWidth (RamAw)
    ) u_ram (
        .i_clk   (S_AXI_ACLK),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (wdata_lut),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_oor  <= 1'b0;
        end else begin
            r_rd_vld <= (w_gnt == GNT_RD);
            if (w_gnt == GNT_RD) begin
                r_rd_pend <= 1'b0;
                r_rd_oor  <= !w_rd_ok;
            end else if (cfg_rd_req) begin
                r_rd_pend <= 1'b1;
            end
            if (cfg_rd_req) begin
                r_rd_addr <= cfg_rd_addr;
            end
        end
    end

    assign cfg_rd_valid = r_rd_vld;
    assign cfg_rd_data  = (r_rd_vld && !r_rd_oor) ? w_ram_rdata : '0;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_n          <= '0;
            r_frame_done <= 1'b0;
            r_fetch_vld  <= 1'b0;
            r_fetch_last <= 1'b0;
            r_fifo_last  <= '0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= '0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (w_flush) begin
                r_ptr       <= '0;
                r_fetch_vld <= 1'b0;
                r_wp        <= 1'b0;
                r_rp        <= 1'b0;
                r_cnt       <= '0;
                if (!go) begin
                    r_state <= IDLE;
                end else begin
                    r_n <= w_n_sof;
                    if (w_n_sof != '0) begin
                        r_state <= STREAM;
                    end else begin
                        r_state      <= DONE;
                        r_frame_done <= 1'b1;
                    end
                end
            end else begin
                r_fetch_vld <= (w_gnt == GNT_FETCH);
                if (w_gnt == GNT_FETCH) begin
                    r_ptr        <= r_ptr + 1'b1;
                    r_fetch_last <= (r_ptr == r_n - 1'b1);
                end
                if (r_fetch_vld) begin
                    r_fifo_data[r_wp] <= bp_entry_t'(w_ram_rdata);
                    r_fifo_last[r_wp] <= r_fetch_last;
                    r_wp              <= !r_wp;
                end
                if (w_pop) begin
                    r_rp <= !r_rp;
                end
                r_cnt <= r_cnt + {1'b0, r_fetch_vld} - {1'b0, w_pop};
                if ((r_state == STREAM) && w_pop && bp_last) begin
                    r_state <= DONE;
                end
            end
        end
    end

    assign frame_done = r_frame_done ||
                        ((r_state == STREAM) && !w_flush && w_pop && bp_last);

`ifdef DPC_BP_SORT_CHECK_EN
    logic [31:0] r_prev;
    logic        r_prev_vld;
    logic        r_sort_err;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_sort_err <= 1'b0;
        end else if (sof) begin
            r_prev_vld <= 1'b0;
            r_sort_err <= 1'b0;
        end else if (w_pop) begin
            if (r_prev_vld && ({bp_y, bp_x} <= r_prev)) begin
                r_sort_err <= 1'b1;
            end
            r_prev     <= {bp_y, bp_x};
            r_prev_vld <= 1'b1;
        end
    end

    assign sort_err = r_sort_err;
`endif

endmodule
